// File: rtl/fdivsqrt_expseq_pkg.sv
// Format tables and sequencer state type for the divide/sqrt exponent unit.
// Table index is the format code: 0 half, 1 single, 2 double, 3 bfloat16.
package fmt_pkg;
  localparam int BIAS_TBL   [4] = '{15, 127, 1023, 127};
  localparam int MAXEXP_TBL [4] = '{30, 254, 2046, 254};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_WAITADJ,
    ST_DONE
  } expseq_state_t;
endpackage

// File: rtl/fdivsqrt_expseq_if.sv
// Request/adjust/result bundle between the requester and the exponent sequencer.
interface fdivsqrt_expseq_if #(
  parameter int NE      = 11,
  parameter int DIVBLEN = 7,
  parameter int FW      = 2
);
  logic                 InValid;
  logic                 InReady;
  logic [FW-1:0]        Fmt;
  logic                 Sqrt;
  logic [NE-1:0]        Xe;
  logic [NE-1:0]        Ye;
  logic [DIVBLEN-1:0]   ell;
  logic [DIVBLEN-1:0]   m;
  logic                 AdjValid;
  logic                 AdjDec;
  logic                 Flush;
  logic                 OutValid;
  logic                 OutReady;
  logic signed [NE+1:0] Ue;
  logic                 SqrtOdd;
  logic                 UeOvf;
  logic                 UeUfl;

  modport master (
    output InValid, Fmt, Sqrt, Xe, Ye, ell, m, AdjValid, AdjDec, Flush, OutReady,
    input  InReady, OutValid, Ue, SqrtOdd, UeOvf, UeUfl
  );

  modport slave (
    input  InValid, Fmt, Sqrt, Xe, Ye, ell, m, AdjValid, AdjDec, Flush, OutReady,
    output InReady, OutValid, Ue, SqrtOdd, UeOvf, UeUfl
  );
endinterface

// File: rtl/fdivsqrt_expseq_expcore.sv
// Combinational result exponent for divide or square root from latched operands.
module fdivsqrt_expcore #(
  parameter int NE      = 11,
  parameter int DIVBLEN = 7
) (
  input  logic                 sqrt_i,
  input  logic [NE-1:0]        xe_i,
  input  logic [NE-1:0]        ye_i,
  input  logic [DIVBLEN-1:0]   ell_i,
  input  logic [DIVBLEN-1:0]   m_i,
  input  logic signed [NE+1:0] bias_i,
  output logic signed [NE+1:0] ue_o,
  output logic                 sqrt_odd_o
);
  localparam int UW = NE + 2;

  logic signed [UW-1:0] xe_s, ye_s, ell_s, m_s;
  logic signed [UW-1:0] s_sqrt, ue_div, ue_sqrt;

  // Two guard bits keep every intermediate in range, so zero-extension is safe.
  always_comb begin
    xe_s       = signed'(UW'(xe_i));
    ye_s       = signed'(UW'(ye_i));
    ell_s      = signed'(UW'(ell_i));
    m_s        = signed'(UW'(m_i));
    s_sqrt     = xe_s - ell_s - bias_i;
    ue_div     = xe_s - ell_s - ye_s + m_s + bias_i;
    ue_sqrt    = (s_sqrt >>> 1) + bias_i;
    ue_o       = sqrt_i ? ue_sqrt : ue_div;
    sqrt_odd_o = sqrt_i & s_sqrt[0];
  end
endmodule

// File: rtl/fdivsqrt_expseq.sv
// Sequential exponent unit: latch operands, compute over STAGES cycles, apply the
// normalisation decrement from the iteration unit, then present the flagged result.
module fdivsqrt_expseq
  import fmt_pkg::*;
#(
  parameter int NE      = 11,
  parameter int DIVBLEN = 7,
  parameter int NFMT    = 4,
  parameter int STAGES  = 2
) (
  input logic              clk,
  input logic              reset_n,
  fdivsqrt_expseq_if.slave bus
);
  localparam int UW = NE + 2;
  localparam int FW = $clog2(NFMT);

  expseq_state_t state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          accept, adj_take;

  logic                 sqrt_q;
  logic [FW-1:0]        fmt_q;
  logic [NE-1:0]        xe_q, ye_q;
  logic [DIVBLEN-1:0]   ell_q, m_q;
  logic signed [UW-1:0] bias, maxe;

  logic signed [UW-1:0] core_ue;
  logic                 core_odd;
  logic signed [UW-1:0] raw_ue_p  [STAGES];
  logic                 raw_odd_p [STAGES];
  logic signed [UW-1:0] raw_ue, ue_adj;
  logic                 raw_odd;

  logic signed [UW-1:0] ue_q;
  logic                 odd_q, ovf_q, ufl_q;

  assign accept   = (state_q == ST_IDLE) & bus.InValid & ~bus.Flush;
  assign adj_take = (state_q == ST_WAITADJ) & bus.AdjValid & ~bus.Flush;

  always_ff @(posedge clk) begin
    if (accept) begin
      sqrt_q <= bus.Sqrt;
      fmt_q  <= bus.Fmt;
      xe_q   <= bus.Xe;
      ye_q   <= bus.Ye;
      ell_q  <= bus.ell;
      m_q    <= bus.m;
    end
  end

  assign bias = UW'(BIAS_TBL[fmt_q]);
  assign maxe = UW'(MAXEXP_TBL[fmt_q]);

  fdivsqrt_expcore #(.NE(NE), .DIVBLEN(DIVBLEN)) u_core (
    .sqrt_i     (sqrt_q),
    .xe_i       (xe_q),
    .ye_i       (ye_q),
    .ell_i      (ell_q),
    .m_i        (m_q),
    .bias_i     (bias),
    .ue_o       (core_ue),
    .sqrt_odd_o (core_odd)
  );

  // Retiming chain: operands are held, so the tail is stable once CALC ends.
  always_ff @(posedge clk) begin
    raw_ue_p[0]  <= core_ue;
    raw_odd_p[0] <= core_odd;
    for (int i = 1; i < STAGES; i++) begin
      raw_ue_p[i]  <= raw_ue_p[i-1];
      raw_odd_p[i] <= raw_odd_p[i-1];
    end
  end

  assign raw_ue  = raw_ue_p[STAGES-1];
  assign raw_odd = raw_odd_p[STAGES-1];
  assign ue_adj  = raw_ue - UW'(bus.AdjDec);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ue_q  <= '0;
      odd_q <= 1'b0;
      ovf_q <= 1'b0;
      ufl_q <= 1'b0;
    end else if (adj_take) begin
      ue_q  <= ue_adj;
      odd_q <= raw_odd;
      ovf_q <= ue_adj > maxe;
      ufl_q <= ue_adj[UW-1] | (ue_adj == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_CALC;
          cnt_d   = 3'(STAGES - 1);
        end
      end
      ST_CALC: begin
        if (cnt_q == 3'd0) state_d = ST_WAITADJ;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_WAITADJ: if (bus.AdjValid) state_d = ST_DONE;
      ST_DONE:    if (bus.OutReady) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (bus.Flush) state_d = ST_IDLE;
  end

  // SqrtOdd is needed by the mantissa pre-shift before the result is final.
  always_comb begin
    bus.InReady  = (state_q == ST_IDLE) & ~bus.Flush;
    bus.OutValid = (state_q == ST_DONE);
    bus.Ue       = ue_q;
    bus.UeOvf    = ovf_q;
    bus.UeUfl    = ufl_q;
    bus.SqrtOdd  = (state_q == ST_WAITADJ) ? raw_odd : odd_q;
  end
endmodule

// File: tb/tb_fdivsqrt_expseq.sv
// Scoreboard bench: four sequencers (STAGES 1..4) share stimulus; each has its own
// expected-result queue drained by a monitor on the output handshake.
`timescale 1ns/1ps
module tb_fdivsqrt_expseq;
  localparam int NE = 11, DIVBLEN = 7, FW = 2, NDUT = 4, UW = NE + 2;

  typedef struct {
    int ue;
    bit odd;
    bit ovf;
    bit ufl;
    int acc;
    bit chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic               in_valid = 1'b0, sqrt = 1'b0, adj_valid = 1'b1, adj_dec = 1'b0;
  logic               flush = 1'b0, out_ready = 1'b1;
  logic [FW-1:0]      fmt = '0;
  logic [NE-1:0]      xe = '0, ye = '0;
  logic [DIVBLEN-1:0] ell = '0, m = '0;

  logic [NDUT-1:0]      rdy_w, ov_w, odd_w, ovf_w, ufl_w;
  logic signed [UW-1:0] ue_w [NDUT];

  exp_t sb [NDUT][$];
  int   checks = 0, failures = 0;
  int   bias_tbl [4] = '{15, 127, 1023, 127};

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(bit sq, int f, int x, int y, int l, int mm, bit dec);
    exp_t e;
    int b = bias_tbl[f];
    int s, u;
    if (sq) begin
      s = x - l - b;
      u = ((s >= 0) ? s / 2 : -((1 - s) / 2)) + b;
      e.odd = (s % 2) != 0;
    end else begin
      u = x - l - y + mm + b;
      e.odd = 1'b0;
    end
    u = u - int'(dec);
    e.ue = u;
    e.ovf = u > 2 * b;
    e.ufl = u <= 0;
    e.acc = 0;
    e.chk_lat = 1'b1;
    return e;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    fdivsqrt_expseq_if #(.NE(NE), .DIVBLEN(DIVBLEN), .FW(FW)) bus ();
    exp_t e;

    assign bus.InValid  = in_valid;
    assign bus.Fmt      = fmt;
    assign bus.Sqrt     = sqrt;
    assign bus.Xe       = xe;
    assign bus.Ye       = ye;
    assign bus.ell      = ell;
    assign bus.m        = m;
    assign bus.AdjValid = adj_valid;
    assign bus.AdjDec   = adj_dec;
    assign bus.Flush    = flush;
    assign bus.OutReady = out_ready;
    assign rdy_w[g]     = bus.InReady;
    assign ov_w[g]      = bus.OutValid;
    assign ue_w[g]      = bus.Ue;
    assign odd_w[g]     = bus.SqrtOdd;
    assign ovf_w[g]     = bus.UeOvf;
    assign ufl_w[g]     = bus.UeUfl;

    fdivsqrt_expseq #(.NE(NE), .DIVBLEN(DIVBLEN), .NFMT(4), .STAGES(g + 1)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
    );

    always @(negedge clk) begin
      if (reset_n && ov_w[g] && out_ready) begin
        if (sb[g].size() == 0) begin
          chk($sformatf("unexpected_out_s%0d", g + 1), 1, 0);
        end else begin
          e = sb[g].pop_front();
          chk($sformatf("ue_s%0d", g + 1), int'(ue_w[g]), e.ue);
          chk($sformatf("sqrtodd_s%0d", g + 1), int'(odd_w[g]), int'(e.odd));
          chk($sformatf("ovf_s%0d", g + 1), int'(ovf_w[g]), int'(e.ovf));
          chk($sformatf("ufl_s%0d", g + 1), int'(ufl_w[g]), int'(e.ufl));
          if (e.chk_lat) chk($sformatf("latency_s%0d", g + 1), cyc - e.acc, g + 3);
        end
      end
    end
  end

  function automatic int pending();
    int n = 0;
    for (int g = 0; g < NDUT; g++) n += sb[g].size();
    return n;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!(&rdy_w) || pending() != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) begin
        chk("idle_timeout", pending(), 0);
        for (int g = 0; g < NDUT; g++) sb[g].delete();
        break;
      end
    end
  endtask

  // Presents one request for one cycle; returns at the start of the first CALC cycle.
  task automatic issue(bit sq, int f, int x, int y, int l, int mm, bit dec, bit push, bit lat);
    exp_t e;
    wait_idle();
    @(posedge clk); #1;
    fmt = FW'(f); sqrt = sq; xe = NE'(x); ye = NE'(y);
    ell = DIVBLEN'(l); m = DIVBLEN'(mm); adj_dec = dec; in_valid = 1'b1;
    e = model(sq, f, x, y, l, mm, dec);
    e.acc = cyc;
    e.chk_lat = lat;
    if (push) for (int g = 0; g < NDUT; g++) sb[g].push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_quiet(string name, int ncyc);
    repeat (ncyc) begin
      @(negedge clk);
      chk(name, int'(ov_w), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, f, b;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      chk("reset_inready", int'(rdy_w[g]), 1);
      chk("reset_outvalid", int'(ov_w[g]), 0);
      chk("reset_ue", int'(ue_w[g]), 0);
      chk("reset_flags", int'({odd_w[g], ovf_w[g], ufl_w[g]}), 0);
    end

    issue(0, 2, 1023, 1023, 0, 0, 1, 1, 1);
    issue(1, 2, 1026, 0, 0, 0, 0, 1, 1);
    issue(1, 2, 1, 0, 5, 0, 0, 1, 1);
    issue(0, 2, 2046, 1, 0, 0, 0, 1, 1);
    issue(0, 2, 1, 2046, 0, 0, 0, 1, 1);
    issue(0, 1, 127, 127, 0, 0, 0, 1, 1);

    for (int i = 0; i < 30; i++) begin
      f = int'($urandom_range(0, 3));
      b = bias_tbl[f];
      issue(1'($urandom_range(0, 1)), f,
            int'($urandom_range(0, 2 * b + 1)), int'($urandom_range(0, 2 * b + 1)),
            int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
            1'($urandom_range(0, 1)), 1, 1);
    end
    wait_idle();

    // Back-pressure: result must hold and a new request must be refused.
    out_ready = 1'b0;
    issue(1, 2, 1026, 0, 0, 0, 0, 1, 0);
    n = 0;
    while (!(&ov_w) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reach_done", int'(&ov_w), 1);
    @(posedge clk); #1;
    in_valid = 1'b1; xe = NE'(5); sqrt = 1'b0;
    repeat (5) begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        chk("hold_ue", int'(ue_w[g]), 1024);
        chk("hold_inready", int'(rdy_w[g]), 0);
        chk("hold_outvalid", int'(ov_w[g]), 1);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    wait_idle();
    check_quiet("no_accept_in_done", 8);

    // Flush while every unit is in CALC.
    issue(0, 2, 2046, 1, 0, 0, 0, 0, 0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_calc_inready", int'(rdy_w), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_calc_idle", int'(rdy_w), 4'hF);
    check_quiet("flush_calc_quiet", 8);

    // Flush together with AdjValid while the STAGES=2 unit sits in WAITADJ.
    out_ready = 1'b0;
    issue(0, 2, 2046, 1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_wait_s2_outvalid", int'(ov_w[1]), 0);
    chk("flush_wait_s1_done", int'(ov_w[0]), 1);
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_wait_idle", int'(rdy_w), 4'hF);
    check_quiet("flush_wait_quiet", 8);

    // Asynchronous reset in the middle of CALC.
    issue(1, 2, 1, 0, 5, 0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      chk("rst_mid_outvalid", int'(ov_w[g]), 0);
      chk("rst_mid_ue", int'(ue_w[g]), 0);
      chk("rst_mid_flags", int'({odd_w[g], ovf_w[g], ufl_w[g]}), 0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_inready", int'(rdy_w), 4'hF);
    check_quiet("rst_mid_quiet", 8);

    issue(0, 1, 127, 127, 0, 0, 0, 1, 1);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
